// File: rtl/layer_buffer_dp.sv
// +-----------------------------------------------------------------------+
// | layer_buffer_dp: true dual-port CNN layer buffer, zero-fill sequencer |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module layer_buffer_dp #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 112,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CK,
  input  logic              rst,
  input  logic              clr_start,
  output logic              ready,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              wr_conflict,
  output logic              oor_err
);

  localparam logic [0:0]        S_CLEAR = 1'b0;
  localparam logic [0:0]        S_IDLE  = 1'b1;
  localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(DEPTH - 1);

  logic [0:0]        r_state;
  logic [0:0]        w_next_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic w_a_acc, w_b_acc, w_a_inr, w_b_inr, w_same;
  logic w_a_wr, w_b_wr, w_b_wr_eff, w_a_rd, w_b_rd;

  always_ff @(posedge CK) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state <= w_next_state;
      // Pointer wraps to 0 as the sweep ends, so every CLEAR entry starts at 0
      if (r_state == S_CLEAR)
        r_clr_ptr <= (r_clr_ptr == c_LAST) ? '0 : r_clr_ptr + ADDR_W'(1);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_ptr == c_LAST) w_next_state = S_IDLE;
      S_IDLE:  if (clr_start)           w_next_state = S_CLEAR;
      default: w_next_state = S_CLEAR;
    endcase
  end

  always_comb begin
    ready = (r_state == S_IDLE);
  end

  assign w_a_acc    = a_req & ready;
  assign w_b_acc    = b_req & ready;
  assign w_a_inr    = {1'b0, a_addr} < c_DEPTH;
  assign w_b_inr    = {1'b0, b_addr} < c_DEPTH;
  assign w_same     = (a_addr == b_addr);
  assign w_a_wr     = w_a_acc & a_we & w_a_inr;
  assign w_b_wr     = w_b_acc & b_we & w_b_inr;
  assign w_b_wr_eff = w_b_wr & ~(w_a_wr & w_same);
  assign w_a_rd     = w_a_acc & ~a_we;
  assign w_b_rd     = w_b_acc & ~b_we;

  always_ff @(posedge CK) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        mem[r_clr_ptr] <= '0;
      end else begin
        if (w_a_wr)     mem[a_addr] <= a_wdata;
        if (w_b_wr_eff) mem[b_addr] <= b_wdata;
      end
    end
  end

  // Same-address read/write in one cycle forwards the other port's new data
  always_ff @(posedge CK) begin
    if (rst) begin
      a_rdata     <= '0;
      b_rdata     <= '0;
      a_rvalid    <= 1'b0;
      b_rvalid    <= 1'b0;
      wr_conflict <= 1'b0;
      oor_err     <= 1'b0;
    end else begin
      a_rvalid    <= w_a_rd;
      b_rvalid    <= w_b_rd;
      wr_conflict <= w_a_wr & w_b_wr & w_same;
      oor_err     <= (w_a_acc & ~w_a_inr) | (w_b_acc & ~w_b_inr);
      if (w_a_rd)
        a_rdata <= !w_a_inr ? '0 : (w_b_wr && w_same) ? b_wdata : mem[a_addr];
      if (w_b_rd)
        b_rdata <= !w_b_inr ? '0 : (w_a_wr && w_same) ? a_wdata : mem[b_addr];
    end
  end

endmodule

`default_nettype wire
